// File: rtl/demux_select_sequencer.sv
// Break-before-make upstream driver for a 1:8 demultiplexer: accepts channel
// requests (or auto-scans 0..7) and sequences I and S2..S0 through SETUP/DRIVE/GUARD.
module demux_select_sequencer #(
   parameter int HOLD_CYCLES = 200,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_sel,
   input  logic       req_data,
   input  logic       scan_en,
   output logic       I,
   output logic       S2,
   output logic       S1,
   output logic       S0,
   output logic       busy,
   output logic       done,
   output logic [2:0] scan_ptr
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_DRIVE,
      ST_GUARD
   } state_t;

   state_t           state, state_nxt;
   logic [2:0]       sel_q, sel_nxt;
   logic             data_q, data_nxt;
   logic [2:0]       scan_ptr_q, scan_ptr_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values and evaluation order cannot matter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         sel_q      <= 3'd0;
         data_q     <= 1'b0;
         scan_ptr_q <= 3'd0;
         cnt_q      <= '0;
      end else begin
         state      <= state_nxt;
         sel_q      <= sel_nxt;
         data_q     <= data_nxt;
         scan_ptr_q <= scan_ptr_nxt;
         cnt_q      <= cnt_nxt;
      end
   end

   // NOTE: every signal written here gets a hold-value default first; a path
   // that skips an assignment would otherwise infer a latch.
   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel_q;
      data_nxt     = data_q;
      scan_ptr_nxt = scan_ptr_q;
      cnt_nxt      = cnt_q;

      case (state)
         ST_IDLE: begin
            // An external request wins over scan and leaves scan_ptr untouched.
            if (req_valid) begin
               sel_nxt   = req_sel;
               data_nxt  = req_data;
               state_nxt = ST_SETUP;
            end else if (scan_en) begin
               sel_nxt      = scan_ptr_q;
               data_nxt     = 1'b1;
               scan_ptr_nxt = scan_ptr_q + 3'd1;
               state_nxt    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_nxt   = '0;
            state_nxt = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (cnt_q == LAST_CNT) begin
               state_nxt = ST_GUARD;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         ST_GUARD: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Selects only load on accept, so they are frozen for the whole SETUP..GUARD
   // window; I is decoded from state and goes low the instant reset asserts.
   assign {S2, S1, S0} = sel_q;
   assign I            = (state == ST_DRIVE) && data_q;
   assign req_ready    = (state == ST_IDLE);
   assign busy         = (state != ST_IDLE);
   assign done         = (state == ST_GUARD);
   assign scan_ptr     = scan_ptr_q;

endmodule
